// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for four requesters that drives the select code of a downstream 4:1 mux.
// Each grant is held until done, until the owner drops its request, or until MAX_HOLD cycles pass.
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] s,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [7:0] HoldMax = 8'(MAX_HOLD);

  state_e     state_q, state_d;
  logic [1:0] s_q, s_d;
  logic [1:0] last_q, last_d;
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;
  logic [1:0] win;
  logic [1:0] rr_idx;
  logic       hold_exp;
  logic       exit_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      s_q       <= 2'b00;
      last_q    <= 2'd3;
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  // Scan from farthest to nearest so the first requester after last_q overwrites the rest.
  always_comb begin
    win    = last_q;
    rr_idx = last_q;
    for (int i = 4; i >= 1; i--) begin
      rr_idx = last_q + 2'(i);
      if (req[rr_idx]) win = rr_idx;
    end
  end

  assign hold_exp   = (hold_q == HoldMax);
  assign exit_grant = done | ~req[s_q] | hold_exp;

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    last_d    = last_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        hold_d = 8'd0;
        if (|req) begin
          state_d = StGrant;
          s_d     = win;
          last_d  = win;
          hold_d  = 8'd1;
        end
      end
      StGrant: begin
        if (hold_q != 8'hff) hold_d = hold_q + 8'd1;
        if (exit_grant) begin
          state_d   = StIdle;
          hold_d    = 8'd0;
          // A normal release in the same cycle as expiry wins over the timeout.
          timeout_d = hold_exp & ~done & req[s_q];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt = 4'b0000;
    if (state_q == StGrant) gnt[s_q] = 1'b1;
    gnt_valid = (state_q == StGrant);
    s         = s_q;
    timeout   = timeout_q;
  end

endmodule
